cache_controller: RTL

- Direct-mapped, write-back, write-allocate cache controller.
- Sits between a CPU-side request port and the single-port data memory (3-bit address, 4-bit data).
- Acts as the initiator of that memory interface: drives write/address/data_in and consumes data_out.
- Memory read data is valid on data_out one clock after the address is presented.

---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_line_array.sv | 30 +++
 rtl/cache_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and sizing for the direct-mapped write-back cache controller.
package cache_pkg;

  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 4;
  localparam int INDEX_W = 1;
  localparam int TAG_W   = ADDR_W - INDEX_W;
  localparam int LINES   = 2 ** INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL,
    FILL_WAIT
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] address);
    return address[INDEX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] address);
    return address[ADDR_W-1:INDEX_W];
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage for the cache: one write port, combinational read by index,
// every line cleared by the asynchronous reset.
module cache_line_array
  import cache_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               write_en,
  input  logic [INDEX_W-1:0] write_index,
  input  line_t              write_line,
  input  logic [INDEX_W-1:0] read_index,
  output line_t              read_line
);

  line_t lines [LINES];

  // Clear all lines on reset, otherwise update the addressed line when enabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) begin
        lines[i] <= '0;
      end
    end else if (write_en) begin
      lines[write_index] <= write_line;
    end
  end

  assign read_line = lines[read_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller between a CPU
// request port and a single-port memory with one cycle of read latency.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_controller
  import cache_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data_in,
  output logic [DATA_W-1:0] cpu_data_out,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
`ifdef CACHE_STATS_EN
  ,
  output logic [7:0]        hit_count,
  output logic [7:0]        miss_count
`endif
);

  state_t             state;
  state_t             next_state;
  logic               req_write;
  logic [ADDR_W-1:0]  req_address;
  logic [DATA_W-1:0]  req_data;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  line_t              cur_line;
  line_t              new_line;
  logic               line_we;
  logic               hit;

  assign req_index = addr_index(req_address);
  assign req_tag   = addr_tag(req_address);
  assign hit       = cur_line.valid && (cur_line.tag == req_tag);
  assign cpu_busy  = (state != IDLE);

  cache_line_array u_lines (
    .clock       (clock),
    .reset_n     (reset_n),
    .write_en    (line_we),
    .write_index (req_index),
    .write_line  (new_line),
    .read_index  (req_index),
    .read_line   (cur_line)
  );

  // State register; reset abandons any request in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the request only when idle, so requests while busy are dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_write   <= 1'b0;
      req_address <= '0;
      req_data    <= '0;
    end else if (state == IDLE && cpu_req) begin
      req_write   <= cpu_write;
      req_address <= cpu_address;
      req_data    <= cpu_data_in;
    end
  end

  // Next state, line update and memory interface, all decoded from state.
  always_comb begin
    next_state  = state;
    line_we     = 1'b0;
    new_line    = cur_line;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          next_state = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          next_state = IDLE;
          if (req_write) begin
            line_we       = 1'b1;
            new_line.dirty = 1'b1;
            new_line.data  = req_data;
          end
        end else if (cur_line.valid && cur_line.dirty) begin
          next_state = WRITEBACK;
        end else begin
          next_state = FILL;
        end
      end
      WRITEBACK: begin
        mem_write   = 1'b1;
        mem_address = {cur_line.tag, req_index};
        mem_data_in = cur_line.data;
        next_state  = FILL;
      end
      FILL: begin
        mem_address = req_address;
        next_state  = FILL_WAIT;
      end
      FILL_WAIT: begin
        mem_address    = req_address;
        line_we        = 1'b1;
        new_line.valid = 1'b1;
        new_line.dirty = req_write;
        new_line.tag   = req_tag;
        new_line.data  = req_write ? req_data : mem_data_out;
        next_state     = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Registered completion pulse and read data; done drops unless set this edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_done     <= 1'b0;
      cpu_data_out <= '0;
    end else begin
      cpu_done <= 1'b0;
      if (state == LOOKUP && hit) begin
        cpu_done     <= 1'b1;
        cpu_data_out <= req_write ? req_data : cur_line.data;
      end else if (state == FILL_WAIT) begin
        cpu_done     <= 1'b1;
        cpu_data_out <= new_line.data;
      end
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating hit/miss counters, bumped once per lookup.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
      end else begin
        if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
      end
    end
  end
`else
  // Default build carries no statistics counters.
`endif

endmodule
